// File: rtl/echo_delay_if.sv
// echo_delay_if: sample stream into and mixed sample stream out of the echo block
interface echo_delay_if;
    logic [15:0] sample_in;
    logic        in_ready;
    logic        enable;
    logic [15:0] sample_out;
    logic        out_valid;
    modport master (output sample_in, in_ready, enable, input sample_out, out_valid);
    modport slave (input sample_in, in_ready, enable, output sample_out, out_valid);
endinterface

// File: rtl/echo_delay.sv
// echo_delay: feedback echo over a circular sample buffer, one sample per in_ready strobe
module echo_delay #(
    parameter int ADDR_WIDTH = 12,
    parameter int DELAY = 2400,
    parameter int DECAY_SHIFT = 1
) (
    input logic clk,
    input logic reset,
    echo_delay_if.slave io
);
    typedef enum logic [1:0] {IDLE, READ, MIX} state_t;
    localparam logic [ADDR_WIDTH-1:0] DLY = ADDR_WIDTH'(DELAY);
    state_t state, state_nx;
    logic [15:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, fill_cnt;
    logic signed [15:0] hold_sample, rd_data, d, mix, sample_out;
    logic signed [16:0] sum;
    logic hold_en, out_valid;
    always_comb begin
        state_nx = state == IDLE ? (io.in_ready ? READ : IDLE) : state == READ ? MIX : IDLE;
        d = fill_cnt < DLY ? 16'sd0 : rd_data >>> DECAY_SHIFT;
        sum = {hold_sample[15], hold_sample} + {d[15], d};
        mix = !hold_en ? hold_sample : sum[16] != sum[15] ? (sum[16] ? 16'sh8000 : 16'sh7fff) : sum[15:0];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            wr_ptr <= '0;
            fill_cnt <= '0;
            sample_out <= '0;
            out_valid <= 1'b0;
            hold_sample <= '0;
            hold_en <= 1'b0;
        end else begin
            state <= state_nx;
            out_valid <= state == MIX;
            if (state == IDLE && io.in_ready) begin
                hold_sample <= io.sample_in;
                hold_en <= io.enable;
            end
            if (state == MIX) begin
                sample_out <= mix;
                wr_ptr <= wr_ptr + 1'b1;
                fill_cnt <= fill_cnt == DLY ? fill_cnt : fill_cnt + 1'b1;
            end
        end
    end
    // buffer is never reset; stale contents stay masked until fill_cnt reaches DELAY
    always_ff @(posedge clk) begin
        if (state == MIX) mem[wr_ptr] <= mix;
        if (state == READ) rd_data <= mem[wr_ptr - DLY];
    end
    assign io.sample_out = sample_out;
    assign io.out_valid = out_valid;
endmodule

// File: tb/tb_echo_delay.sv
// tb_echo_delay: randomized and directed checks of two echo_delay configurations against a sample-history model
module tb_echo_delay;
    localparam int DA = 4;
    localparam int DB = 7;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    int ha[$];
    int hb[$];
    echo_delay_if ia ();
    echo_delay_if ib ();
    echo_delay #(.ADDR_WIDTH(12), .DELAY(DA), .DECAY_SHIFT(1)) dut_a (.clk(clk), .reset(reset), .io(ia));
    echo_delay #(.ADDR_WIDTH(3), .DELAY(DB), .DECAY_SHIFT(1)) dut_b (.clk(clk), .reset(reset), .io(ib));
    always #5 clk = ~clk;

    // expected output = dry sample plus half of the output produced DELAY samples earlier, clamped
    function automatic int model(input bit b, input int x, input bit en);
        int k, dl, d, y;
        k = b ? hb.size() : ha.size();
        dl = b ? DB : DA;
        d = 0;
        if (k >= dl) d = (b ? hb[k - dl] : ha[k - dl]) >>> 1;
        y = x + d;
        if (y > 32767) y = 32767;
        if (y < -32768) y = -32768;
        if (!en) y = x;
        if (b) hb.push_back(y);
        else ha.push_back(y);
        return y;
    endfunction

    task automatic send(input bit b, input int x, input bit en, output int got);
        int e;
        logic [15:0] xs;
        e = model(b, x, en);
        xs = x[15:0];
        if (b) begin ib.sample_in = xs; ib.enable = en; ib.in_ready = 1'b1; end
        else begin ia.sample_in = xs; ia.enable = en; ia.in_ready = 1'b1; end
        @(negedge clk);
        ia.in_ready = 1'b0;
        ib.in_ready = 1'b0;
        n_checks++;
        if ((b ? ib.out_valid : ia.out_valid) !== 1'b0) begin n_fail++; $display("FAIL early_valid1 dut%0d got 1 want 0", b); end
        @(negedge clk);
        n_checks++;
        if ((b ? ib.out_valid : ia.out_valid) !== 1'b0) begin n_fail++; $display("FAIL early_valid2 dut%0d got 1 want 0", b); end
        @(negedge clk);
        n_checks++;
        if ((b ? ib.out_valid : ia.out_valid) !== 1'b1) begin n_fail++; $display("FAIL valid dut%0d got 0 want 1", b); end
        got = $signed(b ? ib.sample_out : ia.sample_out);
        n_checks++;
        if (got !== e) begin n_fail++; $display("FAIL data dut%0d in=%0d got %0d want %0d", b, x, got, e); end
        @(negedge clk);
        n_checks++;
        if ((b ? ib.out_valid : ia.out_valid) !== 1'b0) begin n_fail++; $display("FAIL pulse_len dut%0d got 1 want 0", b); end
        n_checks++;
        if ($signed(b ? ib.sample_out : ia.sample_out) !== got) begin n_fail++; $display("FAIL hold dut%0d got %0d want %0d", b, $signed(b ? ib.sample_out : ia.sample_out), got); end
    endtask

    task automatic do_reset;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ha.delete();
        hb.delete();
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_checks += 4;
        if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_a got %b want 0", ia.out_valid); end
        if (ib.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid_b got %b want 0", ib.out_valid); end
        if (ia.sample_out !== 16'd0) begin n_fail++; $display("FAIL rst_out_a got %0d want 0", ia.sample_out); end
        if (ib.sample_out !== 16'd0) begin n_fail++; $display("FAIL rst_out_b got %0d want 0", ib.sample_out); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_impulse;
        int exp_seq[13] = '{1000, 0, 0, 0, 500, 0, 0, 0, 250, 0, 0, 0, 125};
        int got;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            send(0, i == 0 ? 1000 : 0, 1, got);
            n_checks++;
            if (got !== exp_seq[i]) begin n_fail++; $display("FAIL impulse[%0d] got %0d want %0d", i, got, exp_seq[i]); end
        end
    endtask

    task automatic test_saturation;
        int got;
        do_reset();
        for (int i = 0; i < 5; i++) send(0, 30000, 1, got);
        n_checks++;
        if (got !== 32767) begin n_fail++; $display("FAIL sat_pos got %0d want 32767", got); end
        do_reset();
        for (int i = 0; i < 5; i++) send(0, -30000, 1, got);
        n_checks++;
        if (got !== -32768) begin n_fail++; $display("FAIL sat_neg got %0d want -32768", got); end
    endtask

    task automatic test_back_to_back;
        int e, n;
        e = model(0, 1234, 1);
        ia.sample_in = 16'd1234; ia.enable = 1'b1; ia.in_ready = 1'b1;
        @(negedge clk);
        ia.sample_in = 16'hfcf7;
        @(negedge clk);
        ia.in_ready = 1'b0;
        n_checks++;
        if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early got 1 want 0"); end
        @(negedge clk);
        n_checks += 2;
        if (ia.out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got 0 want 1"); end
        if ($signed(ia.sample_out) !== e) begin n_fail++; $display("FAIL b2b_data got %0d want %0d", $signed(ia.sample_out), e); end
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (ia.out_valid) n++;
        end
        n_checks++;
        if (n !== 0) begin n_fail++; $display("FAIL b2b_extra got %0d extra pulses want 0", n); end
    endtask

    task automatic test_bypass;
        int got;
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            send(0, 100 * i, 0, got);
            n_checks++;
            if (got !== 100 * i) begin n_fail++; $display("FAIL bypass[%0d] got %0d want %0d", i, got, 100 * i); end
        end
        send(0, 0, 1, got);
        n_checks++;
        if (got !== 50) begin n_fail++; $display("FAIL bypass_echo got %0d want 50", got); end
    endtask

    task automatic test_reset_mid;
        int got, bad;
        send(0, 3000, 0, got);
        ia.sample_in = 16'd1000; ia.enable = 1'b1; ia.in_ready = 1'b1;
        @(negedge clk);
        ia.in_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks += 2;
        if (ia.sample_out !== 16'd0) begin n_fail++; $display("FAIL midrst_out got %0d want 0", ia.sample_out); end
        if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got 1 want 0"); end
        @(negedge clk);
        n_checks++;
        if (ia.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid2 got 1 want 0"); end
        reset = 1'b0;
        ha.delete();
        hb.delete();
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            send(0, 0, 1, got);
            if (got != 0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL midrst_echo got %0d nonzero outputs want 0", bad); end
    endtask

    task automatic test_wrap;
        int got;
        for (int i = 0; i < 15; i++) begin
            send(1, i == 0 ? 800 : 0, 1, got);
            if (i == 7) begin
                n_checks++;
                if (got !== 400) begin n_fail++; $display("FAIL wrap_echo got %0d want 400", got); end
            end
        end
    endtask

    task automatic test_random;
        int got, x;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            x = int'($urandom_range(65535)) - 32768;
            send(0, x, 1'($urandom_range(3) != 0), got);
        end
        for (int i = 0; i < 30; i++) begin
            x = int'($urandom_range(65535)) - 32768;
            send(1, x, 1'($urandom_range(3) != 0), got);
        end
    endtask

    initial begin
        ia.sample_in = '0; ia.in_ready = 1'b0; ia.enable = 1'b0;
        ib.sample_in = '0; ib.in_ready = 1'b0; ib.enable = 1'b0;
        test_reset();
        test_impulse();
        test_saturation();
        test_back_to_back();
        test_bypass();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
